arcfour_encrypt: RTL and testbench

- Standalone RC4 (ARCFOUR) encryption engine; the transmit-side counterpart of the decryption core.
- Takes a `KEY_LENGTH`-byte key and a `MESSAGE_LENGTH`-byte plaintext from a read-only byte memory.
- Runs the key schedule in the shared S RAM, then generates keystream and writes `plaintext ^ keystream` into a ciphertext RAM.
- Sits next to the `ramcore`/`romcore` instances and produces ciphertext images the decryption path can consume.

---
 rtl/arcfour_encrypt.sv | 247 ++++++++++++++++++++++++
 tb/tb_arcfour_encrypt.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcfour_encrypt.sv
// arcfour_encrypt: RC4 encryption engine.
// Fills the external S RAM with the identity permutation, runs the key
// schedule, then XORs keystream bytes with plaintext ROM bytes into the
// ciphertext RAM in ascending address order.
// Build option: define ARCFOUR_ENC_DROP256_EN to discard the first 256
// keystream bytes (RC4-drop[256]) before encryption begins.
module arcfour_encrypt #(
   parameter int unsigned KEY_LENGTH         = 3,
   parameter int unsigned MESSAGE_LENGTH     = 32,
   parameter int unsigned MESSAGE_LOG_LENGTH = 5,
   parameter int unsigned RAM_WIDTH          = 8,
   parameter int unsigned RAM_LENGTH         = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [8*KEY_LENGTH-1:0]       key,
   output logic                          busy,
   output logic                          done,
   output logic [RAM_LENGTH-1:0]         sAddr,
   output logic [RAM_WIDTH-1:0]          sIn,
   output logic                          sWren,
   input  logic [RAM_WIDTH-1:0]          sOut,
   output logic [MESSAGE_LOG_LENGTH-1:0] pAddr,
   input  logic [RAM_WIDTH-1:0]          pOut,
   output logic [MESSAGE_LOG_LENGTH-1:0] cAddr,
   output logic [RAM_WIDTH-1:0]          cIn,
   output logic                          cWren
);

   localparam int unsigned KiW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

   typedef enum logic [4:0] {
      StIdle, StInit,
      StK1, StK2, StK3, StK4, StK5, StK6,
      StP1, StP2, StP3, StP4, StP5, StP6, StP7, StP8, StP9,
      StDone
   } state_e;

   state_e                        state_q, state_d;
   logic [RAM_LENGTH-1:0]         i_q, i_d, j_q, j_d;
   logic [MESSAGE_LOG_LENGTH-1:0] k_q, k_d;
   logic [KiW-1:0]                ki_q, ki_d;
   logic [RAM_WIDTH-1:0]          si_q, si_d, sj_q, sj_d, f_q, f_d, p_q, p_d;
   logic [7:0]                    key_byte;
`ifdef ARCFOUR_ENC_DROP256_EN
   logic                          drop_q, drop_d;
   logic [7:0]                    drop_cnt_q, drop_cnt_d;
`endif

   // Key byte for the current KSA step; ki tracks i mod KEY_LENGTH, byte 0 is the MSB byte.
   always_comb begin
      key_byte = key[8*KEY_LENGTH-1 -: 8];
      for (int b = 0; b < int'(KEY_LENGTH); b++) begin
         if (ki_q == KiW'(b)) key_byte = key[8*(int'(KEY_LENGTH)-1-b) +: 8];
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         ki_q       <= '0;
         si_q       <= '0;
         sj_q       <= '0;
         f_q        <= '0;
         p_q        <= '0;
`ifdef ARCFOUR_ENC_DROP256_EN
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         ki_q       <= ki_d;
         si_q       <= si_d;
         sj_q       <= sj_d;
         f_q        <= f_d;
         p_q        <= p_d;
`ifdef ARCFOUR_ENC_DROP256_EN
         drop_q     <= drop_d;
         drop_cnt_q <= drop_cnt_d;
`endif
      end
   end

   // Next-state sequencing and memory-port decode; outputs depend only on registered state.
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      ki_d       = ki_q;
      si_d       = si_q;
      sj_d       = sj_q;
      f_d        = f_q;
      p_d        = p_q;
`ifdef ARCFOUR_ENC_DROP256_EN
      drop_d     = drop_q;
      drop_cnt_d = drop_cnt_q;
`endif
      busy  = !(state_q inside {StIdle, StDone});
      done  = (state_q == StDone);
      sAddr = '0;
      sIn   = '0;
      sWren = 1'b0;
      pAddr = '0;
      cAddr = '0;
      cIn   = '0;
      cWren = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StInit;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               ki_d    = '0;
`ifdef ARCFOUR_ENC_DROP256_EN
               drop_d     = 1'b0;
               drop_cnt_d = '0;
`endif
            end
         end
         StInit: begin
            sAddr = i_q;
            sIn   = RAM_WIDTH'(i_q);
            sWren = 1'b1;
            i_d   = i_q + RAM_LENGTH'(1);
            if (i_q == '1) begin
               state_d = StK1;
               j_d     = '0;
               ki_d    = '0;
            end
         end
         StK1: begin
            sAddr   = i_q;
            state_d = StK2;
         end
         StK2: begin
            si_d    = sOut;
            j_d     = j_q + RAM_LENGTH'(sOut) + RAM_LENGTH'(key_byte);
            ki_d    = (ki_q == KiW'(KEY_LENGTH - 1)) ? '0 : ki_q + KiW'(1);
            state_d = StK3;
         end
         StK3: begin
            sAddr   = j_q;
            state_d = StK4;
         end
         StK4: begin
            sj_d    = sOut;
            state_d = StK5;
         end
         StK5: begin
            sAddr   = i_q;
            sIn     = sj_q;
            sWren   = 1'b1;
            state_d = StK6;
         end
         StK6: begin
            sAddr   = j_q;
            sIn     = si_q;
            sWren   = 1'b1;
            i_d     = i_q + RAM_LENGTH'(1);
            state_d = StK1;
            if (i_q == '1) begin
               state_d = StP1;
               i_d     = RAM_LENGTH'(1);
               j_d     = '0;
               k_d     = '0;
`ifdef ARCFOUR_ENC_DROP256_EN
               drop_d     = 1'b1;
               drop_cnt_d = '0;
`endif
            end
         end
         StP1: begin
            sAddr   = i_q;
            state_d = StP2;
         end
         StP2: begin
            si_d    = sOut;
            j_d     = j_q + RAM_LENGTH'(sOut);
            state_d = StP3;
         end
         StP3: begin
            sAddr   = j_q;
            state_d = StP4;
         end
         StP4: begin
            sj_d    = sOut;
            state_d = StP5;
         end
         StP5: begin
            sAddr   = i_q;
            sIn     = sj_q;
            sWren   = 1'b1;
            state_d = StP6;
         end
         StP6: begin
            sAddr   = j_q;
            sIn     = si_q;
            sWren   = 1'b1;
            state_d = StP7;
`ifdef ARCFOUR_ENC_DROP256_EN
            // Discarded iteration: swap only, no keystream lookup.
            if (drop_q) begin
               state_d    = StP1;
               i_d        = i_q + RAM_LENGTH'(1);
               drop_cnt_d = drop_cnt_q + 8'd1;
               if (drop_cnt_q == 8'hFF) drop_d = 1'b0;
            end
`endif
         end
         StP7: begin
            sAddr   = RAM_LENGTH'(si_q + sj_q);
            pAddr   = k_q;
            state_d = StP8;
         end
         StP8: begin
            f_d     = sOut;
            p_d     = pOut;
            state_d = StP9;
         end
         StP9: begin
            cAddr   = k_q;
            cIn     = f_q ^ p_q;
            cWren   = 1'b1;
            i_d     = i_q + RAM_LENGTH'(1);
            state_d = StP1;
            if (k_q == MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1)) begin
               state_d = StDone;
            end else begin
               k_d = k_q + MESSAGE_LOG_LENGTH'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_arcfour_encrypt.sv
// Self-checking bench for arcfour_encrypt: known-answer table, randomized runs
// against a behavioural RC4 model, start-pulse immunity and asynchronous reset.
module tb_arcfour_encrypt;

`ifdef ARCFOUR_ENC_DROP256_EN
   localparam int DropCycles = 1536;
`else
   localparam int DropCycles = 0;
`endif
   localparam int MsgA   = 32;
   localparam int ExpA   = 1 + 256 + 1536 + 9 * MsgA + DropCycles;
   localparam int ExpB   = 1 + 256 + 1536 + 9 * 5 + DropCycles;
   localparam int Budget = 6000;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Instance A: default parameters
   logic        a_start = 1'b0;
   logic [23:0] a_key   = '0;
   logic        a_busy, a_done, a_s_wren, a_c_wren;
   logic [7:0]  a_s_addr, a_s_in, a_s_out, a_p_out, a_c_in;
   logic [4:0]  a_p_addr, a_c_addr;
   logic [7:0]  a_s_mem [256];
   logic [7:0]  a_p_mem [32];
   logic [7:0]  a_c_mem [32];

   // Instance B: four-byte key, five-byte message
   logic        b_start = 1'b0;
   logic [31:0] b_key   = '0;
   logic        b_busy, b_done, b_s_wren, b_c_wren;
   logic [7:0]  b_s_addr, b_s_in, b_s_out, b_p_out, b_c_in;
   logic [2:0]  b_p_addr, b_c_addr;
   logic [7:0]  b_s_mem [256];
   logic [7:0]  b_p_mem [8];
   logic [7:0]  b_c_mem [8];

   arcfour_encrypt u_dut_a (
      .clk(clk), .reset(reset), .start(a_start), .key(a_key),
      .busy(a_busy), .done(a_done),
      .sAddr(a_s_addr), .sIn(a_s_in), .sWren(a_s_wren), .sOut(a_s_out),
      .pAddr(a_p_addr), .pOut(a_p_out),
      .cAddr(a_c_addr), .cIn(a_c_in), .cWren(a_c_wren)
   );

   arcfour_encrypt #(
      .KEY_LENGTH(4), .MESSAGE_LENGTH(5), .MESSAGE_LOG_LENGTH(3)
   ) u_dut_b (
      .clk(clk), .reset(reset), .start(b_start), .key(b_key),
      .busy(b_busy), .done(b_done),
      .sAddr(b_s_addr), .sIn(b_s_in), .sWren(b_s_wren), .sOut(b_s_out),
      .pAddr(b_p_addr), .pOut(b_p_out),
      .cAddr(b_c_addr), .cIn(b_c_in), .cWren(b_c_wren)
   );

   // Synchronous memories: read data valid the cycle after the address
   always @(posedge clk) begin
      if (a_s_wren) a_s_mem[a_s_addr] <= a_s_in;
      a_s_out <= a_s_mem[a_s_addr];
      a_p_out <= a_p_mem[a_p_addr];
      if (a_c_wren) a_c_mem[a_c_addr] <= a_c_in;
      if (b_s_wren) b_s_mem[b_s_addr] <= b_s_in;
      b_s_out <= b_s_mem[b_s_addr];
      b_p_out <= b_p_mem[b_p_addr];
      if (b_c_wren) b_c_mem[b_c_addr] <= b_c_in;
   end

   // Protocol monitor: one strobe per cycle, ciphertext written in ascending order
   int         strobe_err = 0;
   int         order_err  = 0;
   int         a_wr_total = 0;
   logic [4:0] a_last_c   = 5'd0;
   always @(posedge clk) begin
      if ((a_s_wren && a_c_wren) || (b_s_wren && b_c_wren)) strobe_err <= strobe_err + 1;
      if (a_c_wren) begin
         a_wr_total <= a_wr_total + 1;
         if (a_c_addr != 5'd0 && a_c_addr != a_last_c + 5'd1) order_err <= order_err + 1;
         a_last_c <= a_c_addr;
      end
   end

   // Reference RC4 on plain arrays
   function automatic void rc4_ref(input logic [7:0] kb [4], input int klen,
                                   input logic [7:0] pt [32], input int n,
                                   output logic [7:0] ct [32]);
      logic [7:0] s [256];
      logic [7:0] t;
      int i, j;
      for (int a = 0; a < 256; a++) s[a] = 8'(a);
      j = 0;
      for (int a = 0; a < 256; a++) begin
         j = (j + int'(s[a]) + int'(kb[a % klen])) % 256;
         t = s[a]; s[a] = s[j]; s[j] = t;
      end
      i = 0;
      j = 0;
`ifdef ARCFOUR_ENC_DROP256_EN
      for (int d = 0; d < 256; d++) begin
         i = (i + 1) % 256;
         j = (j + int'(s[i])) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
      end
`endif
      for (int m = 0; m < 32; m++) ct[m] = 8'h00;
      for (int m = 0; m < n; m++) begin
         i = (i + 1) % 256;
         j = (j + int'(s[i])) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         ct[m] = pt[m] ^ s[(int'(s[i]) + int'(s[j])) % 256];
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   logic [7:0] pt_img [32];
   logic [7:0] ref_ct [32];
   logic [7:0] kb     [4];
   int         a_cyc;

   // Load plaintext image into A's ROM and compute the model ciphertext
   task automatic prep_a(input logic [23:0] k);
      kb[0] = k[23:16];
      kb[1] = k[15:8];
      kb[2] = k[7:0];
      kb[3] = 8'h00;
      for (int m = 0; m < 32; m++) a_p_mem[m] = pt_img[m];
      rc4_ref(kb, 3, pt_img, MsgA, ref_ct);
   endtask

   // Present start for one edge; a_cyc counts cycles after the accepting edge
   task automatic start_a(input logic [23:0] k);
      a_key = k;
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk);
      #1 a_start = 1'b0;
      @(negedge clk);
      a_cyc = 1;
      chk("busy_rise", 32'(a_busy), 32'd1);
      chk("done_low_after_start", 32'(a_done), 32'd0);
   endtask

   task automatic step_a();
      @(posedge clk);
      a_cyc++;
      @(negedge clk);
   endtask

   task automatic wait_done_a(input bit pulses);
      while (!a_done && a_cyc < Budget) begin
         if (pulses && (a_cyc == 10 || a_cyc == 500 || a_cyc == 2000)) a_start = 1'b1;
         @(posedge clk);
         #1 a_start = 1'b0;
         a_cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run_check_a(input string name, input logic [23:0] k, input bit pulses);
      int wr0;
      prep_a(k);
      wr0 = a_wr_total;
      start_a(k);
      wait_done_a(pulses);
      chk({name, "_latency"}, 32'(a_cyc), 32'(ExpA));
      chk({name, "_writes"}, 32'(a_wr_total - wr0), 32'(MsgA));
      for (int m = 0; m < MsgA; m++)
         chk($sformatf("%s_ct[%0d]", name, m), 32'(a_c_mem[m]), 32'(ref_ct[m]));
   endtask

   task automatic run_b(input logic [31:0] k, output int cyc);
      b_key = k;
      @(negedge clk);
      b_start = 1'b1;
      @(posedge clk);
      #1 b_start = 1'b0;
      @(negedge clk);
      cyc = 1;
      while (!b_done && cyc < Budget) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
   endtask

`ifndef ARCFOUR_ENC_DROP256_EN
   typedef struct packed {
      logic        is_b;
      logic [31:0] key;
      logic [3:0]  n;
      logic [71:0] pt;
      logic [71:0] ct;
   } vec_t;
   vec_t       vecs [2];
   logic [71:0] ptv, ctv;
`endif

   logic [7:0] orig [32];
   int         cyc_b;

   initial begin
      for (int m = 0; m < 32; m++) a_p_mem[m] = 8'h00;
      for (int m = 0; m < 8; m++) b_p_mem[m] = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_swren", 32'(a_s_wren), 32'd0);
      chk("rst_cwren", 32'(a_c_wren), 32'd0);
      chk("rst_addr_data", {a_s_addr, a_s_in, 3'b0, a_p_addr, 3'b0, a_c_addr},
          32'd0);
      chk("rst_cin", 32'(a_c_in), 32'd0);
      chk("rst_b_busy", 32'(b_busy), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(a_busy), 32'd0);
      chk("idle_swren", 32'(a_s_wren), 32'd0);

`ifndef ARCFOUR_ENC_DROP256_EN
      // Known-answer vectors
      vecs[0] = '{is_b: 1'b0, key: 32'h004B_6579, n: 4'd9,
                  pt: 72'h50_6C_61_69_6E_74_65_78_74,
                  ct: 72'hBB_F3_16_E8_D9_40_AF_0A_D3};
      vecs[1] = '{is_b: 1'b1, key: 32'h5769_6B69, n: 4'd5,
                  pt: 72'h70_65_64_69_61_00_00_00_00,
                  ct: 72'h10_21_BF_04_20_00_00_00_00};
      for (int v = 0; v < 2; v++) begin
         ptv = vecs[v].pt;
         ctv = vecs[v].ct;
         if (!vecs[v].is_b) begin
            for (int m = 0; m < 32; m++) begin
               pt_img[m] = 8'h00;
               if (m < 9) pt_img[m] = ptv[8*(8-m) +: 8];
            end
            run_check_a($sformatf("vec%0d", v), vecs[v].key[23:0], 1'b0);
            for (int m = 0; m < int'(vecs[v].n); m++)
               chk($sformatf("vec%0d_tab[%0d]", v, m), 32'(a_c_mem[m]),
                   32'(ctv[8*(8-m) +: 8]));
         end else begin
            for (int m = 0; m < 5; m++) b_p_mem[m] = ptv[8*(8-m) +: 8];
            run_b(vecs[v].key, cyc_b);
            chk($sformatf("vec%0d_latency", v), 32'(cyc_b), 32'(ExpB));
            for (int m = 0; m < int'(vecs[v].n); m++)
               chk($sformatf("vec%0d_tab[%0d]", v, m), 32'(b_c_mem[m]),
                   32'(ctv[8*(8-m) +: 8]));
         end
      end
`endif

      // Random keys and plaintexts against the model
      for (int r = 0; r < 2; r++) begin
         for (int m = 0; m < 32; m++) pt_img[m] = 8'($urandom);
         run_check_a($sformatf("rand%0d", r), 24'($urandom), 1'b0);
      end

      // start pulses while busy are ignored; start in DONE restarts
      for (int m = 0; m < 32; m++) pt_img[m] = 8'($urandom);
      run_check_a("pulse", 24'($urandom), 1'b1);
      chk("done_held", 32'(a_done), 32'd1);
      for (int m = 0; m < 32; m++) pt_img[m] = 8'($urandom);
      run_check_a("restart", 24'($urandom), 1'b0);

      // Round trip with key 0003FF
      for (int m = 0; m < 32; m++) pt_img[m] = 8'($urandom);
      orig = pt_img;
      run_check_a("rt_enc", 24'h0003FF, 1'b0);
      for (int m = 0; m < 32; m++) pt_img[m] = a_c_mem[m];
      run_check_a("rt_dec", 24'h0003FF, 1'b0);
      for (int m = 0; m < 32; m++)
         chk($sformatf("rt_orig[%0d]", m), 32'(a_c_mem[m]), 32'(orig[m]));

      // Asynchronous reset during INIT
      start_a(24'h123456);
      while (a_cyc < 50) step_a();
      chk("init_swren", 32'(a_s_wren), 32'd1);
      chk("init_saddr", 32'(a_s_addr), 32'd49);
      #2 reset = 1'b0;
      #1;
      chk("rst_init_busy", 32'(a_busy), 32'd0);
      chk("rst_init_swren", 32'(a_s_wren), 32'd0);
      @(negedge clk) reset = 1'b1;

      // Asynchronous reset on the first ciphertext write
      for (int m = 0; m < 32; m++) pt_img[m] = 8'($urandom);
      prep_a(24'hA5C3E1);
      start_a(24'hA5C3E1);
      while (a_cyc < 1801 + DropCycles) step_a();
      chk("p9_cwren", 32'(a_c_wren), 32'd1);
      chk("p9_caddr", 32'(a_c_addr), 32'd0);
      chk("p9_cin", 32'(a_c_in), 32'(ref_ct[0]));
      #2 reset = 1'b0;
      #1;
      chk("rst_p9_busy", 32'(a_busy), 32'd0);
      chk("rst_p9_cwren", 32'(a_c_wren), 32'd0);
      chk("rst_p9_done", 32'(a_done), 32'd0);
      @(negedge clk) reset = 1'b1;

      // Asynchronous reset during KSA (i=100), then a fresh key
      start_a(24'h777777);
      while (a_cyc < 860) step_a();
      chk("ksa_busy", 32'(a_busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rst_ksa_busy", 32'(a_busy), 32'd0);
      @(negedge clk) reset = 1'b1;
      for (int m = 0; m < 32; m++) pt_img[m] = 8'($urandom);
      run_check_a("after_ksa_rst", 24'hC0FFEE, 1'b0);

      // Asynchronous reset in DONE
      chk("done_before_rst", 32'(a_done), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rst_done_level", 32'(a_done), 32'd0);
      @(negedge clk) reset = 1'b1;

      chk("one_strobe_per_cycle", 32'(strobe_err), 32'd0);
      chk("ascending_ct_order", 32'(order_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
